cortina_motor_ctrl: RTL and testbench

Parametrised next-generation curtain motor driver. Drives one H-bridge (direccion + pwm) with:
- per-direction duty and soft-start ramp
- limit-switch stop and direction-reversal dead time
- run timeout with fault latch

Sits between the curtain command decoder (accion) and the motor bridge pins.

---
 rtl/cortina_motor_ctrl_if.sv | 20 ++
 rtl/cortina_motor_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cortina_motor_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cortina_motor_ctrl_if.sv
// Command/limit inputs and H-bridge outputs of the curtain motor driver.
interface cortina_motor_ctrl_if;
   logic [1:0] accion;
   logic       fin_arriba;
   logic       fin_abajo;
   logic [1:0] direccion;
   logic       pwm;
   logic       ocupado;
   logic       falla;

   modport master (
      output accion, fin_arriba, fin_abajo,
      input  direccion, pwm, ocupado, falla
   );

   modport slave (
      input  accion, fin_arriba, fin_abajo,
      output direccion, pwm, ocupado, falla
   );
endinterface

// File: rtl/cortina_motor_ctrl.sv
// Curtain motor H-bridge driver: soft-start PWM per direction, limit stop,
// reversal dead time and run timeout with a latched fault.
module cortina_motor_ctrl #(
   parameter int CW          = 16,
   parameter int PERIODO     = 50000,
   parameter int DUTY_SUBIR  = 50000,
   parameter int DUTY_BAJAR  = 42500,
   parameter int RAMPA_PASO  = 2500,
   parameter int MUERTO      = 100,
   parameter int TW          = 16,
   parameter int TIMEOUT_PER = 20000
) (
   input logic                 clk,
   input logic                 rst_n,
   cortina_motor_ctrl_if.slave bus
);
   typedef enum logic [2:0] {REPOSO, ARRANQUE, MARCHA, FRENO, FALLA} estado_t;

   localparam int CW1 = CW + 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(PERIODO - 1);
   localparam logic [CW:0]   T_UP     = CW1'(DUTY_SUBIR);
   localparam logic [CW:0]   T_DN     = CW1'(DUTY_BAJAR);
   localparam logic [CW:0]   PASO     = CW1'(RAMPA_PASO);
   localparam logic [TW-1:0] DEAD_END = TW'(MUERTO - 1);
   localparam logic [TW-1:0] T_TOUT   = TW'(TIMEOUT_PER);

   // sync[0] is the metastability stage, sync[1] feeds all decisions
   logic [1:0][3:0] sync;
   logic [1:0]      cmd;
   logic            lim_up, lim_dn, both, cmd_up, cmd_dn;

   estado_t       state, state_n;
   logic          up, up_n;
   logic [CW-1:0] cnt, cnt_n, duty, duty_n;
   logic [TW-1:0] run, run_n, dead, dead_n;
   logic [CW:0]   tgt, duty_sum;
   logic          wrap, running_n;

   logic [1:0] direccion_q;
   logic       pwm_q, ocupado_q, falla_q;

   function automatic logic [CW-1:0] sat(input logic [CW:0] a, input logic [CW:0] b);
      return (a < b) ? a[CW-1:0] : b[CW-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= '0;
      end else begin
         sync[0] <= {bus.accion, bus.fin_arriba, bus.fin_abajo};
         sync[1] <= sync[0];
      end
   end

   assign cmd    = sync[1][3:2];
   assign lim_up = sync[1][1];
   assign lim_dn = sync[1][0];
   assign both   = lim_up & lim_dn;
   assign cmd_up = (cmd == 2'b10);
   assign cmd_dn = (cmd == 2'b01);
   assign wrap   = (cnt == CNT_MAX);

   assign tgt      = up ? T_UP : T_DN;
   assign duty_sum = {1'b0, duty} + PASO;

   always_comb begin
      state_n = state;
      up_n    = up;
      cnt_n   = wrap ? '0 : cnt + 1'b1;
      duty_n  = duty;
      run_n   = run;
      dead_n  = dead;
      case (state)
         REPOSO: begin
            cnt_n = '0;
            if (both) begin
               state_n = FALLA;
            end else if (cmd_up && !lim_up) begin
               state_n = ARRANQUE;
               up_n    = 1'b1;
            end else if (cmd_dn && !lim_dn) begin
               state_n = ARRANQUE;
               up_n    = 1'b0;
            end
            if (state_n == ARRANQUE) begin
               duty_n = sat(PASO, up_n ? T_UP : T_DN);
               run_n  = '0;
            end
         end
         ARRANQUE, MARCHA: begin
            if (both) begin
               state_n = FALLA;
            end else if (up ? lim_up : lim_dn) begin
               state_n = FRENO;
            end else if (up ? !cmd_up : !cmd_dn) begin
               state_n = FRENO;
            end else if (run == T_TOUT) begin
               state_n = FALLA;
            end else begin
               if (wrap) begin
                  run_n = run + 1'b1;
                  if (state == ARRANQUE) duty_n = sat(duty_sum, tgt);
               end
               if (state == ARRANQUE && {1'b0, duty} == tgt) state_n = MARCHA;
            end
            if (state_n == FRENO) begin
               cnt_n  = '0;
               dead_n = '0;
            end
            if (state_n == FALLA) cnt_n = '0;
         end
         FRENO: begin
            // commands are ignored here; reversal re-arbitrates from REPOSO
            if (wrap) begin
               dead_n = dead + 1'b1;
               if (dead == DEAD_END) state_n = REPOSO;
            end
         end
         FALLA: begin
            cnt_n = '0;
            if (!cmd_up && !cmd_dn && !both) state_n = REPOSO;
         end
         default: state_n = REPOSO;
      endcase
   end

   assign running_n = (state_n == ARRANQUE) || (state_n == MARCHA);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= REPOSO;
         up    <= 1'b0;
         cnt   <= '0;
         duty  <= '0;
         run   <= '0;
         dead  <= '0;
      end else begin
         state <= state_n;
         up    <= up_n;
         cnt   <= cnt_n;
         duty  <= duty_n;
         run   <= run_n;
         dead  <= dead_n;
      end
   end

   // outputs follow the next state so a stop or start shows at its own edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         direccion_q <= 2'b00;
         pwm_q       <= 1'b0;
         ocupado_q   <= 1'b0;
         falla_q     <= 1'b0;
      end else begin
         direccion_q <= running_n ? (up_n ? 2'b01 : 2'b10) : 2'b00;
         pwm_q       <= running_n && (cnt_n < duty_n);
         ocupado_q   <= running_n || (state_n == FRENO);
         falla_q     <= (state_n == FALLA);
      end
   end

   assign bus.direccion = direccion_q;
   assign bus.pwm       = pwm_q;
   assign bus.ocupado   = ocupado_q;
   assign bus.falla     = falla_q;
endmodule

// File: tb/tb_cortina_motor_ctrl.sv
// Directed and randomized checks of the curtain motor driver against
// period-level expectations and a delayed-input behavioural monitor.
module tb_cortina_motor_ctrl;
   localparam int PER = 100;
   localparam int DS  = 100;
   localparam int DB  = 85;
   localparam int RP  = 25;
   localparam int MU  = 2;
   localparam int TO  = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cortina_motor_ctrl_if bus();

   cortina_motor_ctrl #(
      .CW(16), .PERIODO(PER), .DUTY_SUBIR(DS), .DUTY_BAJAR(DB),
      .RAMPA_PASO(RP), .MUERTO(MU), .TW(16), .TIMEOUT_PER(TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // 0 direccion, 1 pwm, 2 ocupado, 3 falla
   function automatic logic [1:0] sig(input int sel);
      case (sel)
         0:       return bus.direccion;
         1:       return {1'b0, bus.pwm};
         2:       return {1'b0, bus.ocupado};
         default: return {1'b0, bus.falla};
      endcase
   endfunction

   // edges until sig==want; -1 when the budget runs out
   task automatic wait_for(input int sel, input logic [1:0] want, output int e);
      e = -1;
      for (int i = 1; i <= 5000; i++) begin
         @(negedge clk);
         if (sig(sel) === want) begin
            e = i;
            break;
         end
      end
   endtask

   // samples (including the current one) for which sig stays at val
   task automatic run_for(input int sel, input logic [1:0] val, output int n);
      n = 0;
      while (sig(sel) === val && n < 5000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic measure(output int hi);
      hi = 0;
      for (int i = 0; i < PER; i++) begin
         if (bus.pwm === 1'b1) hi++;
         @(negedge clk);
      end
   endtask

   function automatic int ramp(input int k, input int t);
      return (k * RP < t) ? k * RP : t;
   endfunction

   // monitor: outputs after edge n are explained by inputs seen at edge n-2
   typedef struct packed {logic [1:0] a; logic fa; logic fb;} in_t;
   in_t        hq[$];
   logic       mon_on = 1'b0;
   int         off_len = 0;
   int         run_len = 0;
   logic [1:0] prev_dir = 2'b00;
   logic [1:0] last_dir = 2'b00;

   always @(posedge clk) begin
      hq.push_back({bus.accion, bus.fin_arriba, bus.fin_abajo});
      if (hq.size() > 3) void'(hq.pop_front());
   end

   always @(negedge clk) begin
      in_t o;
      if (mon_on && hq.size() == 3) begin
         o = hq[0];
         chk("dir_legal", bus.direccion != 2'b11, 1);
         chk("pwm_needs_dir", bus.pwm && bus.direccion == 2'b00, 0);
         chk("falla_idle", bus.falla && (bus.direccion != 2'b00 || bus.ocupado), 0);
         if (bus.direccion != 2'b00) begin
            chk("busy_in_run", bus.ocupado, 1);
            if (bus.direccion == 2'b01) chk("up_allowed", o.a == 2'b10 && !o.fa, 1);
            else chk("down_allowed", o.a == 2'b01 && !o.fb, 1);
            if (prev_dir != 2'b00) chk("no_flip", bus.direccion, prev_dir);
            if (prev_dir == 2'b00 && last_dir != 2'b00) chk("dead_time", off_len >= MU * PER, 1);
            run_len++;
            off_len = 0;
            last_dir = bus.direccion;
            chk("timeout_bound", run_len <= TO * PER + 1, 1);
         end else begin
            run_len = 0;
            off_len++;
         end
         if (bus.falla) last_dir = 2'b00;
         prev_dir = bus.direccion;
      end
   end

   initial begin
      int e, n, hi, r;
      bus.accion = 2'b00;
      bus.fin_arriba = 1'b0;
      bus.fin_abajo = 1'b0;

      // reset state
      step(3);
      chk("rst_dir", bus.direccion, 0);
      chk("rst_pwm", bus.pwm, 0);
      chk("rst_ocupado", bus.ocupado, 0);
      chk("rst_falla", bus.falla, 0);
      rst_n = 1'b1;
      step(2);

      // raise: ramp 25,50,75,100 then steady 100
      bus.accion = 2'b10;
      wait_for(0, 2'b01, e);
      chk("up_latency", e, 3);
      chk("up_ocupado", bus.ocupado, 1);
      for (int k = 1; k <= 6; k++) begin
         measure(hi);
         chk("up_ramp", hi, ramp(k, DS));
      end

      // stop: FRENO lasts MUERTO periods
      bus.accion = 2'b00;
      wait_for(0, 2'b00, e);
      chk("stop_latency", e, 3);
      run_for(2, 1, n);
      chk("freno_len", n, MU * PER);

      // lower: ramp saturates at DUTY_BAJAR
      bus.accion = 2'b01;
      wait_for(0, 2'b10, e);
      chk("dn_latency", e, 3);
      for (int k = 1; k <= 5; k++) begin
         measure(hi);
         chk("dn_ramp", hi, ramp(k, DB));
      end

      // reversal: FRENO for 200 cycles plus one REPOSO cycle, ramp restarts
      bus.accion = 2'b10;
      wait_for(0, 2'b00, e);
      chk("rev_latency", e, 3);
      run_for(0, 2'b00, n);
      chk("rev_off_len", n, MU * PER + 1);
      chk("rev_dir", bus.direccion, 2'b01);
      for (int k = 1; k <= 3; k++) begin
         measure(hi);
         chk("rev_ramp", hi, ramp(k, DS));
      end

      // top limit stops the run; held raise command is then ignored
      bus.fin_arriba = 1'b1;
      wait_for(0, 2'b00, e);
      chk("lim_latency", e, 3);
      chk("lim_pwm", bus.pwm, 0);
      run_for(2, 1, n);
      chk("lim_freno_len", n, MU * PER);
      step(50);
      chk("lim_ignored_dir", bus.direccion, 0);
      chk("lim_ignored_busy", bus.ocupado, 0);
      bus.accion = 2'b00;
      bus.fin_arriba = 1'b0;
      step(5);

      // timeout: TO periods of running, then fault on the next edge
      bus.accion = 2'b10;
      wait_for(0, 2'b01, e);
      chk("to_start", e, 3);
      run_for(0, 2'b01, n);
      chk("to_run_len", n, TO * PER + 1);
      chk("to_falla", bus.falla, 1);
      chk("to_ocupado", bus.ocupado, 0);
      bus.accion = 2'b00;
      wait_for(3, 2'b00, e);
      chk("falla_clear", e, 3);
      bus.fin_arriba = 1'b1;
      bus.fin_abajo = 1'b1;
      wait_for(3, 2'b01, e);
      chk("both_lim_falla", e, 3);
      step(50);
      chk("both_lim_hold", bus.falla, 1);
      bus.fin_arriba = 1'b0;
      bus.fin_abajo = 1'b0;
      wait_for(3, 2'b00, e);
      chk("both_lim_clear", e, 3);

      // asynchronous reset mid-ramp, restart without dead time
      bus.accion = 2'b10;
      wait_for(0, 2'b01, e);
      step(120);
      chk("pre_rst_pwm", bus.pwm, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_pwm", bus.pwm, 0);
      chk("async_rst_dir", bus.direccion, 0);
      chk("async_rst_busy", bus.ocupado, 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_for(0, 2'b01, e);
      chk("rst_restart", e, 3);
      measure(hi);
      chk("rst_ramp", hi, ramp(1, DS));
      bus.accion = 2'b00;
      wait_for(2, 2'b00, e);
      chk("idle_before_rand", bus.ocupado, 0);

      // randomized commands and limits under the monitor
      mon_on = 1'b1;
      for (int s = 0; s < 30; s++) begin
         r = $urandom_range(0, 9);
         bus.accion = (r < 4) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
         r = $urandom_range(0, 99);
         bus.fin_arriba = (r < 12) || (r >= 94);
         bus.fin_abajo = (r >= 12 && r < 24) || (r >= 94);
         step($urandom_range(1, 400));
      end
      mon_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
